// File: rtl/acs_pkg.sv
// Purpose: shared constants, types and trellis tables for the 4-state ACS stage.
// Latency: n/a (package only).
// Backpressure: n/a; no ports. Holds state count, default widths and the
//               predecessor/branch index tables that wire the ACS cells.
package acs_pkg;

    localparam int NUM_STATES = 4;
    localparam int BM_W_DEF   = 2;
    localparam int PM_W_DEF   = 4;

    typedef logic [BM_W_DEF-1:0] bm_t;
    typedef logic [PM_W_DEF-1:0] pm_t;

    // State s is reached from predecessors {0,1} (s even) or {2,3} (s odd).
    // The "a" candidate is always the even predecessor, so it wins ties.
    localparam int PRED_A [NUM_STATES] = '{0, 2, 0, 2};
    localparam int PRED_B [NUM_STATES] = '{1, 3, 1, 3};

    // Branch metric index (received-symbol hypothesis) used on each transition.
    localparam int BR_A [NUM_STATES] = '{0, 2, 3, 1};
    localparam int BR_B [NUM_STATES] = '{3, 1, 0, 2};

endpackage

// File: rtl/acs_stage_if.sv
// Purpose: bundles the branch-metric input side and path-metric/decision output side.
// Latency: n/a (signal bundle only).
// Backpressure: none; i_valid qualifies inputs, o_valid qualifies outputs.
// Ports: i_valid, i_BM_0..3 (towards ACS), o_PM_0..3, o_dec, o_valid (from ACS).
//        master = branch metric unit side, slave = ACS stage.
interface acs_stage_if #(
    parameter int BM_W = 2,
    parameter int PM_W = 4
);
    logic            i_valid;
    logic [BM_W-1:0] i_BM_0;
    logic [BM_W-1:0] i_BM_1;
    logic [BM_W-1:0] i_BM_2;
    logic [BM_W-1:0] i_BM_3;
    logic [PM_W-1:0] o_PM_0;
    logic [PM_W-1:0] o_PM_1;
    logic [PM_W-1:0] o_PM_2;
    logic [PM_W-1:0] o_PM_3;
    logic [3:0]      o_dec;
    logic            o_valid;

    modport master (
        output i_valid, i_BM_0, i_BM_1, i_BM_2, i_BM_3,
        input  o_PM_0, o_PM_1, o_PM_2, o_PM_3, o_dec, o_valid
    );

    modport slave (
        input  i_valid, i_BM_0, i_BM_1, i_BM_2, i_BM_3,
        output o_PM_0, o_PM_1, o_PM_2, o_PM_3, o_dec, o_valid
    );
endinterface

// File: rtl/acs_cell.sv
// Purpose: one add-compare-select butterfly half: two candidate sums, pick the smaller.
// Latency: combinational.
// Backpressure: none.
// Ports: pm_a_i/pm_b_i predecessor metrics, bm_a_i/bm_b_i branch metrics,
//        sel_o selected sum (one bit wider, never wraps), dec_o 1 = b chosen.
module acs_cell #(
    parameter int BM_W = 2,
    parameter int PM_W = 4
) (
    input  logic [PM_W-1:0] pm_a_i,
    input  logic [PM_W-1:0] pm_b_i,
    input  logic [BM_W-1:0] bm_a_i,
    input  logic [BM_W-1:0] bm_b_i,
    output logic [PM_W:0]   sel_o,
    output logic            dec_o
);
    logic [PM_W:0] cand_a;
    logic [PM_W:0] cand_b;

    assign cand_a = {1'b0, pm_a_i} + {{(PM_W+1-BM_W){1'b0}}, bm_a_i};
    assign cand_b = {1'b0, pm_b_i} + {{(PM_W+1-BM_W){1'b0}}, bm_b_i};

    // Strict less-than: a tie keeps the a candidate.
    assign dec_o = (cand_b < cand_a);
    assign sel_o = dec_o ? cand_b : cand_a;
endmodule

// File: rtl/acs_stage.sv
// Purpose: 4-state Viterbi ACS stage: registered branch metrics, path-metric feedback.
// Latency: BM accepted at edge n drives o_PM/o_dec in cycle n+1; o_valid one cycle.
// Backpressure: none; i_valid=0 freezes bm/pm registers, no ready signal.
// Ports: i_clk, i_rst (sync, active-high), bus (acs_stage_if.slave):
//        i_valid, i_BM_0..3 in; o_PM_0..3, o_dec, o_valid out.
// Build option: ACS_NORM_EN subtracts the minimum selected metric before saturation.
module acs_stage
    import acs_pkg::*;
#(
    parameter int BM_W = BM_W_DEF,
    parameter int PM_W = PM_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    acs_stage_if.slave  bus
);
    logic [BM_W-1:0]       bm_in  [NUM_STATES];
    logic [BM_W-1:0]       bm_q   [NUM_STATES];
    logic [BM_W-1:0]       bm_d   [NUM_STATES];
    logic [PM_W-1:0]       pm_q   [NUM_STATES];
    logic [PM_W-1:0]       pm_d   [NUM_STATES];
    logic [PM_W-1:0]       pm_nxt [NUM_STATES];
    logic [PM_W:0]         sel    [NUM_STATES];
    logic [PM_W:0]         adj    [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic                  valid_q;

    assign bm_in[0] = bus.i_BM_0;
    assign bm_in[1] = bus.i_BM_1;
    assign bm_in[2] = bus.i_BM_2;
    assign bm_in[3] = bus.i_BM_3;

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_cell
        acs_cell #(
            .BM_W (BM_W),
            .PM_W (PM_W)
        ) u_cell (
            .pm_a_i (pm_q[PRED_A[s]]),
            .pm_b_i (pm_q[PRED_B[s]]),
            .bm_a_i (bm_q[BR_A[s]]),
            .bm_b_i (bm_q[BR_B[s]]),
            .sel_o  (sel[s]),
            .dec_o  (dec[s])
        );
    end

`ifdef ACS_NORM_EN
    logic [PM_W:0] sel_min;

    always_comb begin
        sel_min = sel[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (sel[s] < sel_min) begin
                sel_min = sel[s];
            end
        end
        for (int s = 0; s < NUM_STATES; s++) begin
            adj[s] = sel[s] - sel_min;
        end
    end
`else
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            adj[s] = sel[s];
        end
    end
`endif

    // adj is PM_W+1 bits, so its MSB set means it exceeds the PM_W-bit maximum.
    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            pm_nxt[s] = adj[s][PM_W] ? {PM_W{1'b1}} : adj[s][PM_W-1:0];
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            bm_d[s] = bus.i_valid ? bm_in[s]  : bm_q[s];
            pm_d[s] = bus.i_valid ? pm_nxt[s] : pm_q[s];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            for (int s = 0; s < NUM_STATES; s++) begin
                bm_q[s] <= '0;
                pm_q[s] <= '0;
            end
        end else begin
            valid_q <= bus.i_valid;
            for (int s = 0; s < NUM_STATES; s++) begin
                bm_q[s] <= bm_d[s];
                pm_q[s] <= pm_d[s];
            end
        end
    end

    assign bus.o_PM_0  = pm_nxt[0];
    assign bus.o_PM_1  = pm_nxt[1];
    assign bus.o_PM_2  = pm_nxt[2];
    assign bus.o_PM_3  = pm_nxt[3];
    assign bus.o_dec   = dec;
    assign bus.o_valid = valid_q;
endmodule

// File: tb/tb_acs_stage.sv
// Purpose: scoreboard bench for acs_stage against a trellis-level reference model.
// Latency: expected outputs are pushed one edge after stimulus and popped by a monitor.
// Backpressure: none; stimulus drives one cycle per step, optionally with i_valid low.
module tb_acs_stage;
    localparam int BM_W   = 2;
    localparam int PM_W   = 4;
    localparam int PM_MAX = (1 << PM_W) - 1;

    typedef struct packed {
        logic            vld;
        logic [3:0][3:0] pm;
        logic [3:0]      dec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acs_stage_if #(.BM_W(BM_W), .PM_W(PM_W)) bus ();

    acs_stage #(.BM_W(BM_W), .PM_W(PM_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q [$];

    // Reference state: path metrics, branch metrics of the last accepted symbol.
    int m_pm [4];
    int m_bm [4];
    bit m_vld;

    // Rate-1/2 encoder of the code: state p = {p1,p0}, input bit u.
    function automatic int enc_sym(int p, int u);
        int p0;
        int p1;
        p0 = p & 1;
        p1 = (p >> 1) & 1;
        return (((u ^ p1 ^ p0) & 1) << 1) | ((u ^ p0) & 1);
    endfunction

    // Next state after input u from state p is {u, p1}; try every predecessor.
    function automatic exp_t model_out();
        exp_t e;
        int   best [4];
        int   mn;
        e     = '0;
        e.vld = m_vld;
        for (int ns = 0; ns < 4; ns++) begin
            best[ns] = 1 << 30;
            for (int p = 0; p < 4; p++) begin
                if (((p >> 1) == (ns & 1))) begin
                    int cost;
                    cost = m_pm[p] + m_bm[enc_sym(p, ns >> 1)];
                    // Even predecessor is visited first, so ties keep it.
                    if (cost < best[ns]) begin
                        best[ns]  = cost;
                        e.dec[ns] = (p & 1) ? 1'b1 : 1'b0;
                    end
                end
            end
        end
        mn = best[0];
        for (int s = 1; s < 4; s++) if (best[s] < mn) mn = best[s];
        for (int s = 0; s < 4; s++) begin
            int v;
`ifdef ACS_NORM_EN
            v = best[s] - mn;
`else
            v = best[s];
`endif
            if (v > PM_MAX) v = PM_MAX;
            e.pm[s] = v[3:0];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int b0, input int b1,
                        input int b2, input int b3);
        exp_t nxt;
        @(negedge clk);
        rst         = r;
        bus.i_valid = v;
        bus.i_BM_0  = b0[1:0];
        bus.i_BM_1  = b1[1:0];
        bus.i_BM_2  = b2[1:0];
        bus.i_BM_3  = b3[1:0];
        @(posedge clk);
        #1;
        if (r) begin
            for (int s = 0; s < 4; s++) begin
                m_pm[s] = 0;
                m_bm[s] = 0;
            end
            m_vld = 1'b0;
        end else begin
            if (v) begin
                nxt = model_out();
                for (int s = 0; s < 4; s++) m_pm[s] = int'(nxt.pm[s]);
                m_bm[0] = b0 & 3;
                m_bm[1] = b1 & 3;
                m_bm[2] = b2 & 3;
                m_bm[3] = b3 & 3;
            end
            m_vld = v;
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: outputs depend only on registers, so sample mid-cycle after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_valid", {31'd0, bus.o_valid}, {31'd0, e.vld});
                chk("o_PM_0", {28'd0, bus.o_PM_0}, {28'd0, e.pm[0]});
                chk("o_PM_1", {28'd0, bus.o_PM_1}, {28'd0, e.pm[1]});
                chk("o_PM_2", {28'd0, bus.o_PM_2}, {28'd0, e.pm[2]});
                chk("o_PM_3", {28'd0, bus.o_PM_3}, {28'd0, e.pm[3]});
                chk("o_dec",  {28'd0, bus.o_dec},  {28'd0, e.dec});
            end
        end
    end

    initial begin
        int drain;
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_BM_0  = 2'd3;
        bus.i_BM_1  = 2'd3;
        bus.i_BM_2  = 2'd3;
        bus.i_BM_3  = 2'd3;
        for (int s = 0; s < 4; s++) begin
            m_pm[s] = 0;
            m_bm[s] = 0;
        end
        m_vld = 1'b0;

        // Reset wins over i_valid with non-zero metrics.
        step(1, 1, 3, 3, 3, 3);
        step(1, 1, 3, 3, 3, 3);

        // Equal metrics: climbs by one per symbol until saturation.
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 1, 1);

        // Distinct metrics, feedback steps, then a stall with changing inputs.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 2, 3);
        step(0, 1, 2, 0, 1, 3);
        step(0, 1, 1, 2, 3, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
        step(0, 1, 3, 1, 0, 2);
        step(0, 1, 0, 0, 0, 0);

        // Random run with a reset in the middle.
        for (int i = 0; i < 1000; i++) begin
            step((i == 500) ? 1'b1 : 1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Let the monitor drain the scoreboard within a bounded number of cycles.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
